// File: rtl/src_bf16_fmt_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | src_bf16_fmt_if : upstream/downstream stream bundle for src_bf16_fmt  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface src_bf16_fmt_if;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_ready;
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_last;
  logic        m_ready;

  // master: the environment (DMA source and accelerator sink)
  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );

  // slave: the formatter itself
  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_last
  );
endinterface
`default_nettype wire

// File: rtl/src_bf16_fmt.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | src_bf16_fmt : FP32->bf16 / raw stream formatter with last generation |
// | and a 2-entry output FIFO. SRC_BF16_FMT_RNE_EN selects RNE rounding.  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module src_bf16_fmt #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] len,
  input  logic        raw,
  src_bf16_fmt_if.slave bus,
  output logic [15:0] pkt_cnt,
  output logic        busy
);

  localparam logic [1:0] c_full = 2'(DEPTH);

  logic [11:0] r_cnt;
  logic [11:0] r_len_q;
  logic        r_raw_q;
  logic [1:0]  r_occ;
  logic [31:0] r_hd_data;
  logic        r_hd_last;
  logic [31:0] r_tl_data;
  logic        r_tl_last;
  logic [15:0] r_pkt_cnt;

  logic        w_push;
  logic        w_pop;
  logic        w_first;
  logic [11:0] w_len;
  logic        w_raw;
  logic        w_last_in;
  logic        w_nan;
  logic        w_inc;
  logic [15:0] w_bf;
  logic [31:0] w_word;

  assign bus.s_ready = (r_occ != c_full);
  assign bus.m_valid = (r_occ != 2'd0);
  assign bus.m_data  = r_hd_data;
  assign bus.m_last  = r_hd_last;
  assign pkt_cnt     = r_pkt_cnt;
  assign busy        = (r_cnt != 12'd0) || (r_occ != 2'd0);

  assign w_push = bus.s_valid && bus.s_ready;
  assign w_pop  = bus.m_valid && bus.m_ready;

  // The first word of a packet already uses the freshly sampled len/raw.
  assign w_first   = (r_cnt == 12'd0);
  assign w_len     = w_first ? len : r_len_q;
  assign w_raw     = w_first ? raw : r_raw_q;
  assign w_last_in = (r_cnt == w_len);

  assign w_nan = (&bus.s_data[30:23]) && (|bus.s_data[22:0]);
`ifdef SRC_BF16_FMT_RNE_EN
  assign w_inc = bus.s_data[15] && (bus.s_data[16] || (|bus.s_data[14:0]));
`else
  assign w_inc = 1'b0;
`endif
  assign w_bf   = w_nan ? (bus.s_data[31:16] | 16'h0040)
                        : (bus.s_data[31:16] + {15'd0, w_inc});
  assign w_word = w_raw ? bus.s_data : {w_bf, 16'h0000};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= 12'd0;
      r_len_q <= 12'd0;
      r_raw_q <= 1'b0;
    end else if (w_push) begin
      if (w_first) begin
        r_len_q <= len;
        r_raw_q <= raw;
      end
      r_cnt <= w_last_in ? 12'd0 : r_cnt + 12'd1;
    end
  end

  // Head register drives m_*; tail only holds the second entry when full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ     <= 2'd0;
      r_hd_data <= 32'd0;
      r_hd_last <= 1'b0;
      r_tl_data <= 32'd0;
      r_tl_last <= 1'b0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_occ == 2'd0) begin
            r_hd_data <= w_word;
            r_hd_last <= w_last_in;
          end else begin
            r_tl_data <= w_word;
            r_tl_last <= w_last_in;
          end
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          if (r_occ == 2'd2) begin
            r_hd_data <= r_tl_data;
            r_hd_last <= r_tl_last;
          end
          r_occ <= r_occ - 2'd1;
        end
        2'b11: begin
          r_hd_data <= w_word;
          r_hd_last <= w_last_in;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pkt_cnt <= 16'd0;
    end else if (w_pop && r_hd_last) begin
      r_pkt_cnt <= r_pkt_cnt + 16'd1;
    end
  end

endmodule
`default_nettype wire
